// File: rtl/sync_fifo_param_pkg.sv
// Shared defaults and sizing helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;

  // Never returns less than 1 so a pointer always has at least one bit.
  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a FIFO and its producer/consumer.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  import fifo_pkg::*;

  localparam int CNT_W = clog2_safe(DEPTH) + 1;

  logic              flush;
  logic              wr;
  logic [DATA_W-1:0] din;
  logic              rd;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              almost_full;
  logic              empty;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr, din, rd,
    input  dout, dout_valid, full, almost_full, empty, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr, din, rd,
    output dout, dout_valid, full, almost_full, empty, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_param_mem.sv
// Simple dual-port register array with a synchronous write port and a
// registered read port; a same-address write/read returns the old word.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [clog2_safe(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic                         re,
  input  logic [clog2_safe(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]            rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is cleared; array contents are left as-is.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count, threshold flags
// and sticky error flags around a dual-port register array.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave bus
);

  localparam int PTR_W = clog2_safe(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LVL);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             vld_p1;
  logic             overflow;
  logic             underflow;
  logic             full;
  logic             empty;
  logic             rd_acc;
  logic             wr_acc;
  logic             mem_we;
  logic             mem_re;

  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign rd_acc = bus.rd & ~empty;
  assign wr_acc = bus.wr & (~full | rd_acc);

  // Flush (and reset) suppress any array access in that cycle.
  assign mem_we = wr_acc & ~bus.flush & ~rst;
  assign mem_re = rd_acc & ~bus.flush;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wptr),
    .wdata (bus.din),
    .re    (mem_re),
    .raddr (rptr),
    .rdata (bus.dout)
  );

  // Stage p0 -> p1: pointer, count and read-valid update on the clock edge.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (wr_acc) wptr <= wptr + PTR_W'(1);
      if (rd_acc) rptr <= rptr + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Error flags are sticky across flush and clear only on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!bus.flush) begin
      if (bus.wr && full && !rd_acc) overflow  <= 1'b1;
      if (bus.rd && empty)           underflow <= 1'b1;
    end
  end

  assign bus.dout_valid   = vld_p1;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= CNT_AF);
  assign bus.almost_empty = (count <= CNT_AE);
  assign bus.count        = count;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: default 8x16 instance plus a 32x4 instance.
module tb_sync_fifo_param;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sync_fifo_param_if #(.DATA_W(8),  .DEPTH(16)) bus_a ();
  sync_fifo_param_if #(.DATA_W(32), .DEPTH(4))  bus_b ();

  sync_fifo_param #(.DATA_W(8), .DEPTH(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  sync_fifo_param #(.DATA_W(32), .DEPTH(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.wr = 1'b0; bus_a.rd = 1'b0; bus_a.flush = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.wr = 1'b0; bus_b.rd = 1'b0; bus_b.flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_empty"}, 32'(bus_a.empty), 32'd1);
    chk({tag, "_full"},  32'(bus_a.full), 32'd0);
    chk({tag, "_ae"},    32'(bus_a.almost_empty), 32'd1);
    chk({tag, "_af"},    32'(bus_a.almost_full), 32'd0);
    chk({tag, "_count"}, 32'(bus_a.count), 32'd0);
    chk({tag, "_dout"},  32'(bus_a.dout), 32'd0);
    chk({tag, "_dv"},    32'(bus_a.dout_valid), 32'd0);
    chk({tag, "_ovf"},   32'(bus_a.overflow), 32'd0);
    chk({tag, "_unf"},   32'(bus_a.underflow), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_a(); idle_b();
    bus_a.din = '0; bus_b.din = '0;
    tick();
    do_reset();
    chk_reset_a("rst0");

    // Scenario 1: fill 0x01..0x10, then one write too many.
    for (int i = 1; i <= 16; i++) begin
      bus_a.wr = 1'b1; bus_a.din = 8'(i);
      tick();
      chk($sformatf("s1_count%0d", i), 32'(bus_a.count), 32'(i));
      chk($sformatf("s1_af%0d", i), 32'(bus_a.almost_full), (i >= 14) ? 32'd1 : 32'd0);
    end
    chk("s1_full", 32'(bus_a.full), 32'd1);
    chk("s1_ovf_before", 32'(bus_a.overflow), 32'd0);
    bus_a.din = 8'h77;
    tick();
    chk("s1_ovf", 32'(bus_a.overflow), 32'd1);
    chk("s1_count_hold", 32'(bus_a.count), 32'd16);
    idle_a();

    // Scenario 2: drain in order, then one read too many.
    for (int i = 1; i <= 16; i++) begin
      bus_a.rd = 1'b1;
      tick();
      chk($sformatf("s2_dout%0d", i), 32'(bus_a.dout), 32'(i));
      chk($sformatf("s2_dv%0d", i), 32'(bus_a.dout_valid), 32'd1);
    end
    chk("s2_empty", 32'(bus_a.empty), 32'd1);
    chk("s2_unf_before", 32'(bus_a.underflow), 32'd0);
    tick();
    chk("s2_unf", 32'(bus_a.underflow), 32'd1);
    chk("s2_dout_hold", 32'(bus_a.dout), 32'h10);
    chk("s2_dv_low", 32'(bus_a.dout_valid), 32'd0);
    idle_a();
    tick();

    // Scenario 3: steady stream at occupancy 5.
    for (int i = 0; i < 5; i++) begin
      bus_a.wr = 1'b1; bus_a.din = 8'(8'h20 + i);
      tick();
    end
    chk("s3_count5", 32'(bus_a.count), 32'd5);
    for (int k = 0; k < 40; k++) begin
      bus_a.wr = 1'b1; bus_a.rd = 1'b1; bus_a.din = 8'(8'h25 + k);
      tick();
      chk($sformatf("s3_count_k%0d", k), 32'(bus_a.count), 32'd5);
      chk($sformatf("s3_dout_k%0d", k), 32'(bus_a.dout), 32'(8'h20 + k));
    end
    idle_a();
    for (int k = 0; k < 5; k++) begin
      bus_a.rd = 1'b1;
      tick();
      chk($sformatf("s3_drain%0d", k), 32'(bus_a.dout), 32'(8'h48 + k));
    end
    idle_a();
    chk("s3_empty", 32'(bus_a.empty), 32'd1);

    // Scenario 4: simultaneous read/write on a full FIFO.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus_a.wr = 1'b1; bus_a.din = 8'(8'h30 + i);
      tick();
    end
    bus_a.rd = 1'b1; bus_a.din = 8'hAA;
    tick();
    chk("s4_dout", 32'(bus_a.dout), 32'h30);
    chk("s4_count", 32'(bus_a.count), 32'd16);
    chk("s4_ovf", 32'(bus_a.overflow), 32'd0);
    idle_a();
    for (int i = 1; i <= 16; i++) begin
      bus_a.rd = 1'b1;
      tick();
      chk($sformatf("s4_drain%0d", i), 32'(bus_a.dout), (i == 16) ? 32'hAA : 32'(8'h30 + i));
    end
    idle_a();
    tick();

    // Scenario 5: simultaneous read/write on an empty FIFO.
    bus_a.wr = 1'b1; bus_a.rd = 1'b1; bus_a.din = 8'h55;
    tick();
    chk("s5_count", 32'(bus_a.count), 32'd1);
    chk("s5_dv", 32'(bus_a.dout_valid), 32'd0);
    chk("s5_unf", 32'(bus_a.underflow), 32'd1);
    chk("s5_dout_hold", 32'(bus_a.dout), 32'hAA);
    idle_a();
    bus_a.rd = 1'b1;
    tick();
    chk("s5_read", 32'(bus_a.dout), 32'h55);
    chk("s5_read_dv", 32'(bus_a.dout_valid), 32'd1);
    idle_a();
    tick();

    // Scenario 6: flush with a concurrent write, then reset.
    for (int i = 0; i < 7; i++) begin
      bus_a.wr = 1'b1; bus_a.din = 8'(8'h60 + i);
      tick();
    end
    bus_a.flush = 1'b1; bus_a.wr = 1'b1; bus_a.din = 8'hEE;
    tick();
    chk("s6_count", 32'(bus_a.count), 32'd0);
    chk("s6_empty", 32'(bus_a.empty), 32'd1);
    chk("s6_unf_hold", 32'(bus_a.underflow), 32'd1);
    chk("s6_ovf_hold", 32'(bus_a.overflow), 32'd0);
    chk("s6_dout_hold", 32'(bus_a.dout), 32'h55);
    idle_a();
    bus_a.wr = 1'b1; bus_a.din = 8'h71;
    tick();
    idle_a();
    bus_a.rd = 1'b1;
    tick();
    chk("s6_after_flush", 32'(bus_a.dout), 32'h71);
    chk("s6_after_flush_cnt", 32'(bus_a.count), 32'd0);
    idle_a();
    bus_a.wr = 1'b1; bus_a.din = 8'h99;
    tick();
    idle_a();
    do_reset();
    chk_reset_a("rst1");

    // Narrow-depth, wide-word instance: fill, overflow, drain, underflow.
    do_reset();
    chk("b_rst_empty", 32'(bus_b.empty), 32'd1);
    chk("b_rst_dout", bus_b.dout, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      bus_b.wr = 1'b1; bus_b.din = 32'hA000_0000 + 32'(i);
      tick();
      chk($sformatf("b_count%0d", i), 32'(bus_b.count), 32'(i));
      chk($sformatf("b_af%0d", i), 32'(bus_b.almost_full), (i >= 2) ? 32'd1 : 32'd0);
    end
    chk("b_full", 32'(bus_b.full), 32'd1);
    bus_b.din = 32'hDEAD_BEEF;
    tick();
    chk("b_ovf", 32'(bus_b.overflow), 32'd1);
    chk("b_count_hold", 32'(bus_b.count), 32'd4);
    idle_b();
    for (int i = 1; i <= 4; i++) begin
      bus_b.rd = 1'b1;
      tick();
      chk($sformatf("b_dout%0d", i), bus_b.dout, 32'hA000_0000 + 32'(i));
      chk($sformatf("b_dv%0d", i), 32'(bus_b.dout_valid), 32'd1);
    end
    chk("b_empty", 32'(bus_b.empty), 32'd1);
    tick();
    chk("b_unf", 32'(bus_b.underflow), 32'd1);
    chk("b_dout_hold", bus_b.dout, 32'hA000_0004);
    idle_b();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous single-clock FIFO. It is the next-generation buffer for streaming datapaths and the bench interface layer. Generalises the 8-bit x 16 FIFO with configurable width and depth, true simultaneous read/write, programmable almost-full/almost-empty thresholds, an occupancy count, flush, and sticky overflow/underflow error flags.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of 2, >=4
AF_LVL, DEPTH-2, almost_full asserts when count >= AF_LVL
AE_LVL, 2, almost_empty asserts when count <= AE_LVL
(localparam) PTR_W = $clog2(DEPTH); CNT_W = PTR_W+1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  synchronous clear of pointers/count; memory contents untouched
wr  in  1  write request
din  in  DATA_W  write data
rd  in  1  read request
dout  out  DATA_W  read data, registered
dout_valid  out  1  one-cycle pulse: dout updated this cycle
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_LVL
empty  out  1  count == 0
almost_empty  out  1  count <= AE_LVL
count  out  CNT_W  current occupancy 0..DEPTH
overflow  out  1  sticky: write attempted while full with no accepted read
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1): wptr=rptr=0, count=0, dout=0, dout_valid=0, overflow=underflow=0. Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0 (given AF_LVL>0).
- Priority: rst > flush > normal operation. flush: wptr=rptr=0, count=0, dout_valid=0. dout holds its value, sticky flags hold. wr/rd in the flush cycle are ignored and do not set error flags.
- rd_acc = rd & !empty. wr_acc = wr & (!full | rd_acc). Full flags are evaluated on pre-edge state.
- rd_acc: dout <= mem[rptr], rptr+1 (wraps mod DEPTH), dout_valid=1 on the next cycle only. Read latency is 1 clock.
- wr_acc: mem[wptr] <= din, wptr+1 (wraps mod DEPTH).
- count: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Simultaneous rd & wr:
  - When empty, the write is accepted and the read is rejected (no fall-through); underflow sets.
  - When full, both are accepted and count stays DEPTH.
- Write to the same address as a read in the same cycle (only possible when full): the read returns the old data.
- overflow sets when wr & full & !rd_acc. underflow sets when rd & empty. Both clear only on rst.
- Flags and count are combinational from registered count; no extra latency.
- Rejected operations leave all state except the sticky flags unchanged.
- Pointer wrap: PTR_W-bit natural rollover. Occupancy is tracked only by count, so there is no full/empty pointer ambiguity.
- Reset mid-burst discards all contents. The first read after reset returns data written after reset.

Decomposition:
- Package fifo_pkg: default DATA_W/DEPTH constants, and the function clog2_safe for the PTR_W/CNT_W derivation.
- Sub-module fifo_mem: simple dual-port register array, DATA_W x DEPTH. Inputs: synchronous write port (we, waddr, wdata) and registered read port (re, raddr, rdata). No reset on array contents.
- Top level holds pointers, count, flags and error logic. Target is about 200 lines total.

Test Plan:
1. Reset, then write 0x01..0x10 (DEPTH=16) -> full=1, count=16, almost_full asserted from count=14. A 17th write sets overflow=1 and count stays 16.
2. Read 16 words from full -> dout=0x01..0x10 in order, each one cycle after rd with dout_valid pulse; empty=1 after the last. A further rd sets underflow=1 and dout holds 0x10.
3. Hold wr=rd=1 with count=5 for 40 cycles, streaming incrementing data -> count stays 5 throughout, pointers wrap more than twice, output order is preserved.
4. Full FIFO, wr=rd=1 with din=0xAA -> dout=oldest word, count=16, overflow stays 0, and 0xAA is read back last.
5. Empty FIFO, wr=rd=1 with din=0x55 -> count=1, dout_valid=0, underflow=1. The next rd returns 0x55.
6. Write 7 words then assert flush together with wr=1 -> count=0, empty=1, no write occurs, and overflow/underflow hold. Next, rst -> all outputs at their reset values. Finally, a parameter sweep with DATA_W=32, DEPTH=4 repeats scenarios 1-2.
